ch8_maxpool: RTL



---
 rtl/fdt_pkg.sv | 10 +
 rtl/ch8_maxpool_if.sv | 31 +++
 rtl/ch8_vmax.sv | 23 ++
 rtl/ch8_maxpool.sv | 77 +++++++
 4 files changed

// File: rtl/fdt_pkg.sv
// Shared types for the ip_fdt activation datapath (ReLU stage, pooling stages).
package fdt_pkg;

    localparam int N_LANE  = 8;
    localparam int LANE_DW = 8;

    // One activation beat: N_LANE signed lanes, lane 0 in the low bits.
    typedef logic [N_LANE-1:0][LANE_DW-1:0] vec8_t;

endpackage

// File: rtl/ch8_maxpool_if.sv
// Stream bundle for the 8-channel max-pool.
// Input side: in_*. Output side: out_*, Z_out. Debug: win_cnt.
interface ch8_maxpool_if #(
    parameter int DW  = 8,
    parameter int WIN = 4
);
    import fdt_pkg::*;

    localparam int CW = $clog2(WIN);

    logic                          clr;
    logic                          in_vld;
    logic                          in_rdy;
    logic [N_LANE-1:0][DW-1:0]     A_in;
    logic                          in_last;
    logic                          out_vld;
    logic                          out_rdy;
    logic [N_LANE-1:0][DW-1:0]     Z_out;
    logic [CW-1:0]                 win_cnt;

    modport master (
        output clr, in_vld, A_in, in_last, out_rdy,
        input  in_rdy, out_vld, Z_out, win_cnt
    );

    modport slave (
        input  clr, in_vld, A_in, in_last, out_rdy,
        output in_rdy, out_vld, Z_out, win_cnt
    );

endinterface

// File: rtl/ch8_vmax.sv
// Lane-wise signed maximum of two 8-lane vectors.
// Ties return a, so a running accumulator on a keeps its value on equality.
module ch8_vmax
    import fdt_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [N_LANE-1:0][DW-1:0] a,
    input  logic [N_LANE-1:0][DW-1:0] b,
    output logic [N_LANE-1:0][DW-1:0] y
);

    // Per-lane signed compare; b replaces a only when strictly greater.
    always_comb begin
        y = a;
        for (int i = 0; i < N_LANE; i++) begin
            if ($signed(b[i]) > $signed(a[i])) begin
                y[i] = b[i];
            end
        end
    end

endmodule

// File: rtl/ch8_maxpool.sv
// Streaming 8-channel temporal max-pool.
// Folds every WIN accepted beats (or a shorter group closed by in_last) into
// one vector of per-lane signed maxima, presented through a single registered
// output stage. Full throughput: a window close and an output consume can
// happen in the same cycle without a bubble.
module ch8_maxpool
    import fdt_pkg::*;
#(
    parameter int DW  = 8,
    parameter int WIN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ch8_maxpool_if.slave  bus
);

    localparam int CW = $clog2(WIN);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIN - 1);

    logic [N_LANE-1:0][DW-1:0] acc_q;
    logic [N_LANE-1:0][DW-1:0] z_q;
    logic [N_LANE-1:0][DW-1:0] max_v;
    logic [N_LANE-1:0][DW-1:0] new_v;
    logic [CW-1:0]             cnt_q;
    logic                      out_vld_q;
    logic                      in_rdy;
    logic                      acc_fire;
    logic                      out_fire;
    logic                      win_close;

    ch8_vmax #(.DW(DW)) u_vmax (
        .a (acc_q),
        .b (bus.A_in),
        .y (max_v)
    );

    // Handshake qualifiers; the first beat of a window seeds acc directly so
    // leftovers from an earlier window can never leak into a new maximum.
    always_comb begin
        in_rdy    = !bus.clr && (!out_vld_q || bus.out_rdy);
        acc_fire  = bus.in_vld && in_rdy;
        out_fire  = out_vld_q && bus.out_rdy;
        win_close = acc_fire && ((cnt_q == CNT_LAST) || bus.in_last);
        new_v     = (cnt_q == '0) ? bus.A_in : max_v;
    end

    // Window accumulation, counter and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            z_q       <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
        end else if (bus.clr) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (acc_fire) begin
                acc_q <= new_v;
                cnt_q <= win_close ? '0 : cnt_q + 1'b1;
            end
            if (win_close) begin
                z_q       <= new_v;
                out_vld_q <= 1'b1;
            end else if (out_fire) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign bus.in_rdy  = in_rdy;
    assign bus.out_vld = out_vld_q;
    assign bus.Z_out   = z_q;
    assign bus.win_cnt = cnt_q;

endmodule
